// File: rtl/mux_2_to_1_pkg.sv
// mux_2_to_1_pkg: shared constants and helpers for the 2:1 instruction selector.
//   INSTRUCTION_WIDTH : fallback for the global define (32) when global_defines.sv
//                       is not part of the compile.
//   MUX_STAT_W        : width of the usage counters (16).
//   stat_t / sat_inc  : counter type and saturating increment.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

package mux_2_to_1_pkg;

  localparam int unsigned MUX_STAT_W = 16;

  typedef logic [MUX_STAT_W-1:0] stat_t;

  localparam stat_t STAT_MAX = '1;

  // Counters stick at all-ones instead of wrapping.
  function automatic stat_t sat_inc(input stat_t v, input logic en);
    return (en && (v != STAT_MAX)) ? v + stat_t'(1) : v;
  endfunction

endpackage

// File: rtl/mux_2_to_1_if.sv
// mux_2_to_1_if: datapath bundle for the 2:1 selector.
//   in_0, in_1, selector        : driven by the producer (master)
//   out, out_q, sel_q, out_q_valid : driven by the selector (slave)
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

interface mux_2_to_1_if #(
  parameter int unsigned WIDTH = `INSTRUCTION_WIDTH
);

  logic [WIDTH-1:0] in_0;
  logic [WIDTH-1:0] in_1;
  logic             selector;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             sel_q;
  logic             out_q_valid;

  modport master (
    output in_0, in_1, selector,
    input  out, out_q, sel_q, out_q_valid
  );

  modport slave (
    input  in_0, in_1, selector,
    output out, out_q, sel_q, out_q_valid
  );

endinterface

// File: rtl/mux_2_to_1_stats.sv
// mux_2to1_stats: saturating usage counters for the 2:1 selector.
//   clk, rst_n     : clock, synchronous active-low reset
//   sel            : selector as sampled this cycle (already resolved to 0/1)
//   sel_q          : selector sampled on the previous edge
//   out_q_valid    : previous sample exists since reset
//   sel0_count     : edges sampled with sel = 0
//   sel1_count     : edges sampled with sel = 1
//   switch_count   : edges where sel differs from the previous sample
module mux_2to1_stats
  import mux_2_to_1_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  sel,
  input  logic  sel_q,
  input  logic  out_q_valid,
  output stat_t sel0_count,
  output stat_t sel1_count,
  output stat_t switch_count
);

  logic switch_evt;

  // No previous sample right after reset, so the first edge is never a switch.
  assign switch_evt = out_q_valid && (sel != sel_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel0_count   <= '0;
      sel1_count   <= '0;
      switch_count <= '0;
    end else begin
      sel0_count   <= sat_inc(sel0_count, !sel);
      sel1_count   <= sat_inc(sel1_count, sel);
      switch_count <= sat_inc(switch_count, switch_evt);
    end
  end

endmodule

// File: rtl/mux_2_to_1.sv
// mux_2_to_1: instruction-width 2:1 selector with a registered copy.
//   clk, rst_n   : clock, synchronous active-low reset (registered outputs only)
//   bus (slave)  : in_0/in_1/selector in; out (combinational), out_q, sel_q,
//                  out_q_valid out
//   sel0_count, sel1_count, switch_count : usage counters, present only when
//                  MUX_2TO1_STATS_EN is defined
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module mux_2_to_1
  import mux_2_to_1_pkg::*;
#(
  parameter int unsigned WIDTH = `INSTRUCTION_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  mux_2_to_1_if.slave bus
`ifdef MUX_2TO1_STATS_EN
  ,
  output stat_t       sel0_count,
  output stat_t       sel1_count,
  output stat_t       switch_count
`endif
);

  logic             sel_eff;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_q_r;
  logic             sel_q_r;
  logic             valid_r;

  // An unknown selector fails the if-test and falls to in_0, so X/Z never
  // reaches out or the registered selector copy.
  always_comb begin
    sel_eff = 1'b0;
    out_c   = bus.in_0;
    if (bus.selector == 1'b1) begin
      sel_eff = 1'b1;
      out_c   = bus.in_1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q_r <= '0;
      sel_q_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      out_q_r <= out_c;
      sel_q_r <= sel_eff;
      valid_r <= 1'b1;
    end
  end

  assign bus.out         = out_c;
  assign bus.out_q       = out_q_r;
  assign bus.sel_q       = sel_q_r;
  assign bus.out_q_valid = valid_r;

`ifdef MUX_2TO1_STATS_EN
  mux_2to1_stats u_stats (
    .clk          (clk),
    .rst_n        (rst_n),
    .sel          (sel_eff),
    .sel_q        (sel_q_r),
    .out_q_valid  (valid_r),
    .sel0_count   (sel0_count),
    .sel1_count   (sel1_count),
    .switch_count (switch_count)
  );
`endif

endmodule

// File: tb/tb_mux_2_to_1.sv
// tb_mux_2_to_1: self-checking bench for mux_2_to_1 (counter checks are active
// when MUX_2TO1_STATS_EN is defined).
`timescale 1ns/1ps

module tb_mux_2_to_1;

  logic clk;
  logic rst_n;

  mux_2_to_1_if #(.WIDTH(32)) mif ();

`ifdef MUX_2TO1_STATS_EN
  logic [15:0] sel0_count;
  logic [15:0] sel1_count;
  logic [15:0] switch_count;
`endif

  mux_2_to_1 #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (mif)
`ifdef MUX_2TO1_STATS_EN
    ,
    .sel0_count   (sel0_count),
    .sel1_count   (sel1_count),
    .switch_count (switch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: what the registered outputs and counters should hold,
  // tracked as plain integers and sampled-history values.
  logic [31:0] m_out_q;
  bit          m_sel_q;
  bit          m_valid;
  int          m_sel0;
  int          m_sel1;
  int          m_sw;

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [31:0] ref_out();
    return (mif.selector === 1'b1) ? mif.in_1 : mif.in_0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_comb(input string name);
    check(name, mif.out, ref_out());
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".out_q"}, mif.out_q, m_out_q);
    check({tag, ".sel_q"}, {31'd0, mif.sel_q}, {31'd0, m_sel_q});
    check({tag, ".valid"}, {31'd0, mif.out_q_valid}, {31'd0, m_valid});
`ifdef MUX_2TO1_STATS_EN
    check({tag, ".sel0_count"}, {16'd0, sel0_count}, {16'd0, sat16(m_sel0)});
    check({tag, ".sel1_count"}, {16'd0, sel1_count}, {16'd0, sat16(m_sel1)});
    check({tag, ".switch_count"}, {16'd0, switch_count}, {16'd0, sat16(m_sw)});
`endif
  endtask

  // One clock edge: capture what the edge samples, advance the model, then
  // settle 1ns past the edge before anything is compared or driven.
  task automatic tick();
    bit          s;
    logic [31:0] o;
    bit          r;
    s = (mif.selector === 1'b1);
    o = ref_out();
    r = rst_n;
    @(posedge clk);
    if (!r) begin
      m_out_q = '0;
      m_sel_q = 1'b0;
      m_valid = 1'b0;
      m_sel0  = 0;
      m_sel1  = 0;
      m_sw    = 0;
    end else begin
      if (m_valid && (s != m_sel_q)) m_sw++;
      if (s) m_sel1++;
      else   m_sel0++;
      m_out_q = o;
      m_sel_q = s;
      m_valid = 1'b1;
    end
    #1;
  endtask

  typedef struct {
    logic [31:0] in0;
    logic [31:0] in1;
    logic        sel;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'h0000_1100, 32'h0000_0011, 1'b0, 32'h0000_1100};
    vecs[1] = '{32'h0000_1100, 32'h0000_0011, 1'b1, 32'h0000_0011};
    vecs[2] = '{32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000};
    vecs[5] = '{32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 32'hA5A5_A5A5};

    m_out_q = '0; m_sel_q = 0; m_valid = 0; m_sel0 = 0; m_sel1 = 0; m_sw = 0;
    rst_n        = 1'b0;
    mif.in_0     = 32'h0000_1100;
    mif.in_1     = 32'h0000_0011;
    mif.selector = 1'b0;

    // Reset state.
    tick();
    tick();
    check_regs("reset");
    check("reset.out", mif.out, 32'h0000_1100);

    // Table vectors: same-cycle out, registered copy one edge later.
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mif.in_0     = vecs[i].in0;
      mif.in_1     = vecs[i].in1;
      mif.selector = vecs[i].sel;
      #1;
      check($sformatf("vec%0d.out", i), mif.out, vecs[i].exp_out);
      tick();
      check($sformatf("vec%0d.out_q", i), mif.out_q, vecs[i].exp_out);
      check_regs($sformatf("vec%0d", i));
    end

    // Unknown selector resolves to in_0.
    mif.in_0 = 32'hDEAD_BEEF;
    mif.in_1 = 32'h0BAD_F00D;
    mif.selector = 1'bz;
    #1;
    check("selz.out", mif.out, 32'hDEAD_BEEF);
    tick();
    check_regs("selz");
    mif.selector = 1'bx;
    #1;
    check("selx.out", mif.out, 32'hDEAD_BEEF);
    tick();
    check_regs("selx");

    // Mid-operation reset held two cycles with toggling inputs.
    mif.selector = 1'b1;
    tick();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mif.in_0 = $urandom;
      mif.in_1 = $urandom;
      mif.selector = i[0];
      #1;
      check_comb($sformatf("rst%0d.out", i));
      tick();
      check_regs($sformatf("rst%0d", i));
      check($sformatf("rst%0d.valid0", i), {31'd0, mif.out_q_valid}, 32'd0);
    end
    rst_n = 1'b1;
    tick();
    check("rel.valid1", {31'd0, mif.out_q_valid}, 32'd1);
    check_regs("rel");

`ifdef MUX_2TO1_STATS_EN
    // Counter pattern 0,0,1,0 from a fresh reset.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mif.selector = (i == 2);
      tick();
    end
    check("pat.sel0", {16'd0, sel0_count}, 32'd3);
    check("pat.sel1", {16'd0, sel1_count}, 32'd1);
    check("pat.switch", {16'd0, switch_count}, 32'd2);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      mif.in_0     = $urandom;
      mif.in_1     = $urandom;
      mif.selector = $urandom_range(0, 1);
      rst_n        = ($urandom_range(0, 19) != 0);
      #1;
      check_comb("rand.out");
      tick();
      check_regs("rand");
    end

`ifdef MUX_2TO1_STATS_EN
    // Saturation: selector held high well past the counter range.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mif.selector = 1'b1;
    for (int i = 0; i < 70000; i++) tick();
    check("sat.sel1", {16'd0, sel1_count}, 32'h0000_FFFF);
    check_regs("sat");
    for (int i = 0; i < 3; i++) tick();
    check("sat.hold", {16'd0, sel1_count}, 32'h0000_FFFF);
    check_regs("sat_hold");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
